// File: rtl/kf_pkg.sv
// Shared definitions for the kf_top measurement feeder: default widths, the
// sequencer FSM states and the two's-complement / sign-magnitude conversions.
package kf_pkg;

    localparam int KF_W     = 24;
    localparam int KF_FRAC  = 14;
    localparam int KF_ADDRW = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        READ1,
        READ2,
        OUT
    } kf_state_t;

    // The most negative two's-complement value has no sign-magnitude twin, so it saturates.
    function automatic logic [KF_W-1:0] tc2sm(input logic [KF_W-1:0] v);
        logic [KF_W-1:0] neg;
        neg = -v;
        if (!v[KF_W-1]) begin
            return v;
        end
        if (v[KF_W-2:0] == '0) begin
            return '1;
        end
        return {1'b1, neg[KF_W-2:0]};
    endfunction

    function automatic logic [KF_W-1:0] sm2tc(input logic [KF_W-1:0] v);
        logic [KF_W-1:0] mag;
        mag = {1'b0, v[KF_W-2:0]};
        return v[KF_W-1] ? -mag : mag;
    endfunction

endpackage

// File: rtl/kf_fmt_conv.sv
// Combinational number-format converter; TO_SM selects two's complement to
// sign-magnitude (with saturation) or sign-magnitude back to two's complement.
module kf_fmt_conv
    import kf_pkg::*;
#(
    parameter int W     = KF_W,
    parameter bit TO_SM = 1'b1
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] mag;

    always_comb begin
        if (TO_SM) begin
            mag = din[W-1] ? -din : din;
            // Negating -2^(W-1) wraps back onto itself, which is the only case leaving the MSB set.
            if (din[W-1] && mag[W-1]) begin
                dout = '1;
            end else begin
                dout = {din[W-1], mag[W-2:0]};
            end
        end else begin
            mag  = {1'b0, din[W-2:0]};
            dout = din[W-1] ? -mag : mag;
        end
    end

endmodule

// File: rtl/kf_meas_feeder.sv
// Host-side sequencer for kf_top: loads six init words, waits for READY, reads x_hat back.
// Optional macro KF_FEEDER_CARRY_EN carries the last read x_hat into the next job's x0 word.
module kf_meas_feeder
    import kf_pkg::*;
#(
    parameter int W       = KF_W,
    parameter int FRAC    = KF_FRAC,
    parameter int ADDRW   = KF_ADDRW,
    parameter int XADDR   = 0,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    input  logic [W-1:0]     cfg_phi,
    input  logic [W-1:0]     cfg_q,
    input  logic [W-1:0]     cfg_r,
    input  logic [W-1:0]     cfg_x0,
    input  logic [W-1:0]     cfg_p0,
    output logic             kf_start,
    output logic [W-1:0]     kf_data_in,
    output logic [ADDRW-1:0] kf_dir,
    output logic             kf_write,
    input  logic             kf_ready,
    input  logic [W-1:0]     kf_data_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data,
    output logic             m_err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    if (FRAC >= W - 1) begin : g_bad_frac
        $error("FRAC must leave room for the sign and integer bits");
    end

    kf_state_t      state, state_n;
    logic [2:0]     k, k_n;
    logic [7:0]     wait_cnt, wait_cnt_n;
    logic           seen_busy, seen_busy_n;
    logic [W-1:0]   phi, q, r, x0, p0, y;
    logic [W-1:0]   phi_n, q_n, r_n, x0_n, p0_n, y_n;
    logic           s_ready_n, kf_start_n, m_valid_n, m_err_n;
    logic [W-1:0]   kf_data_in_n, m_data_n;
    logic [ADDRW-1:0] kf_dir_n;
    logic [W-1:0]   y_sm, x_tc, x0_word;

    kf_fmt_conv #(.W(W), .TO_SM(1'b1)) u_tc2sm (.din(s_data),      .dout(y_sm));
    kf_fmt_conv #(.W(W), .TO_SM(1'b0)) u_sm2tc (.din(kf_data_out), .dout(x_tc));

    assign kf_write = 1'b0;

`ifdef KF_FEEDER_CARRY_EN
    logic           first, first_n;
    logic [W-1:0]   carry, carry_n;
    assign x0_word = first ? x0 : carry;
`else
    assign x0_word = x0;
`endif

    always_comb begin
        state_n      = state;
        k_n          = k;
        wait_cnt_n   = wait_cnt;
        seen_busy_n  = seen_busy;
        phi_n        = phi;
        q_n          = q;
        r_n          = r;
        x0_n         = x0;
        p0_n         = p0;
        y_n          = y;
        s_ready_n    = s_ready;
        kf_start_n   = 1'b0;
        kf_data_in_n = kf_data_in;
        kf_dir_n     = kf_dir;
        m_valid_n    = m_valid;
        m_data_n     = m_data;
        m_err_n      = m_err;
`ifdef KF_FEEDER_CARRY_EN
        first_n      = first;
        carry_n      = carry;
`endif
        case (state)
            IDLE: begin
                s_ready_n = 1'b1;
                if (s_valid && s_ready) begin
                    phi_n     = cfg_phi;
                    q_n       = cfg_q;
                    r_n       = cfg_r;
                    x0_n      = cfg_x0;
                    p0_n      = cfg_p0;
                    y_n       = y_sm;
                    s_ready_n = 1'b0;
                    k_n       = 3'd0;
                    state_n   = LOAD;
                end
            end
            LOAD: begin
                kf_start_n = (k == 3'd0);
                case (k)
                    3'd0:    kf_data_in_n = phi;
                    3'd1:    kf_data_in_n = q;
                    3'd2:    kf_data_in_n = r;
                    3'd3:    kf_data_in_n = x0_word;
                    3'd4:    kf_data_in_n = p0;
                    default: kf_data_in_n = y;
                endcase
                k_n = k + 3'd1;
                if (k == 3'd5) begin
                    wait_cnt_n  = '0;
                    seen_busy_n = 1'b0;
                    state_n     = WAIT;
                end
            end
            WAIT: begin
                // A READY left high by the previous job only counts once it has dropped.
                kf_data_in_n = '0;
                if (!kf_ready) begin
                    seen_busy_n = 1'b1;
                end
                if (seen_busy && kf_ready) begin
                    state_n = READ1;
                end else if (wait_cnt == TO_LAST) begin
                    m_valid_n = 1'b1;
                    m_err_n   = 1'b1;
                    m_data_n  = '0;
                    state_n   = OUT;
                end else begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end
            READ1: begin
                kf_dir_n = ADDRW'(XADDR);
                state_n  = READ2;
            end
            READ2: begin
                m_valid_n = 1'b1;
                m_err_n   = 1'b0;
                m_data_n  = x_tc;
`ifdef KF_FEEDER_CARRY_EN
                first_n   = 1'b0;
                carry_n   = kf_data_out;
`endif
                state_n   = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_n = 1'b0;
                    s_ready_n = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            wait_cnt   <= '0;
            seen_busy  <= 1'b0;
            phi        <= '0;
            q          <= '0;
            r          <= '0;
            x0         <= '0;
            p0         <= '0;
            y          <= '0;
            s_ready    <= 1'b0;
            kf_start   <= 1'b0;
            kf_data_in <= '0;
            kf_dir     <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_err      <= 1'b0;
`ifdef KF_FEEDER_CARRY_EN
            first      <= 1'b1;
            carry      <= '0;
`endif
        end else begin
            state      <= state_n;
            k          <= k_n;
            wait_cnt   <= wait_cnt_n;
            seen_busy  <= seen_busy_n;
            phi        <= phi_n;
            q          <= q_n;
            r          <= r_n;
            x0         <= x0_n;
            p0         <= p0_n;
            y          <= y_n;
            s_ready    <= s_ready_n;
            kf_start   <= kf_start_n;
            kf_data_in <= kf_data_in_n;
            kf_dir     <= kf_dir_n;
            m_valid    <= m_valid_n;
            m_data     <= m_data_n;
            m_err      <= m_err_n;
`ifdef KF_FEEDER_CARRY_EN
            first      <= first_n;
            carry      <= carry_n;
`endif
        end
    end

endmodule
